// File: rtl/fixed_point_segment_classifier.sv
`default_nettype none
// ============================================================================
// Module   : fixed_point_segment_classifier
// Purpose  : Two-stage pipelined classifier for signed fixed-point samples.
//            Each accepted sample is compared against NUM_THRESH programmable
//            breakpoints. The block reports how many breakpoints are <= the
//            sample (the segment index) and whether the sample equals any of
//            them. Results use valid/ready flow control with backpressure.
//            The block also keeps running min/max statistics over delivered
//            samples.
// Ports    : clk, rst_n          clock (rising edge), async active-low reset
//            cfg_we/addr/data    breakpoint write port
//            in_valid/ready/data input sample stream
//            out_valid/ready     result handshake
//            out_data/seg/eq     sample, segment index, equality flag
//            stat_clr            clears the running statistics
//            stat_valid/min/max  running statistics over delivered samples
// Revision : 1.0 - initial release
// ============================================================================
module fixed_point_segment_classifier #(
    parameter int WIDTH      = 12,
    parameter int FRAC_BITS  = 6,
    parameter int NUM_THRESH = 4,
    localparam int AW = (NUM_THRESH > 1) ? $clog2(NUM_THRESH) : 1,
    localparam int IW = $clog2(NUM_THRESH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [IW-1:0]    out_seg,
    output logic             out_eq,
    input  logic             stat_clr,
    output logic             stat_valid,
    output logic [WIDTH-1:0] stat_min,
    output logic [WIDTH-1:0] stat_max
);

    // The binary point position only affects how values are interpreted
    // upstream. Ordering is identical to plain signed integers.
    if (FRAC_BITS < 0 || FRAC_BITS >= WIDTH) begin : g_frac_range_check
        $error("FRAC_BITS must lie in [0, WIDTH-1]");
    end
    if (NUM_THRESH < 1) begin : g_num_thresh_check
        $error("NUM_THRESH must be at least 1");
    end

    localparam logic [WIDTH-1:0] C_MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] C_MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // Breakpoint registers
    logic [WIDTH-1:0]      thresh_q [NUM_THRESH];

    // Stage 1: sample plus raw comparison vectors
    logic                  s1_valid_q;
    logic [WIDTH-1:0]      s1_data_q;
    logic [NUM_THRESH-1:0] s1_ge_q, s1_eq_q;
    logic [NUM_THRESH-1:0] ge_d, eq_d;

    // Stage 2: reduced result presented at the output
    logic                  s2_valid_q;
    logic [WIDTH-1:0]      s2_data_q;
    logic [IW-1:0]         s2_seg_q, seg_d;
    logic                  s2_eq_q, s2_eq_d;

    // Statistics
    logic                  stat_valid_q, stat_valid_d;
    logic [WIDTH-1:0]      stat_min_q, stat_min_d;
    logic [WIDTH-1:0]      stat_max_q, stat_max_d;

    logic                  s2_adv, s1_adv, accept, out_hs;

    // Each stage may move when its successor frees up in the same cycle, so
    // bubbles collapse and a full pipe still streams one sample per cycle.
    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;
    assign accept   = in_valid && in_ready;
    assign out_hs   = s2_valid_q && out_ready;

    // Compare against the registered breakpoints. A write in the same cycle
    // lands only at the clock edge, so it applies to later samples only.
    always_comb begin
        ge_d = '0;
        eq_d = '0;
        for (int i = 0; i < NUM_THRESH; i++) begin
            ge_d[i] = $signed(in_data) >= $signed(thresh_q[i]);
            eq_d[i] = in_data == thresh_q[i];
        end
    end

    // Segment index is the population count. This holds even when the
    // breakpoints are not programmed in ascending order.
    always_comb begin
        seg_d = '0;
        for (int i = 0; i < NUM_THRESH; i++) begin
            seg_d = seg_d + IW'(s1_ge_q[i]);
        end
        s2_eq_d = |s1_eq_q;
    end

    // Breakpoint writes. Out-of-range addresses match no entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_THRESH; i++) begin
                thresh_q[i] <= '0;
            end
        end else if (cfg_we) begin
            for (int i = 0; i < NUM_THRESH; i++) begin
                if (cfg_addr == AW'(i)) begin
                    thresh_q[i] <= cfg_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_ge_q    <= '0;
            s1_eq_q    <= '0;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_data_q <= in_data;
                s1_ge_q   <= ge_d;
                s1_eq_q   <= eq_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_seg_q   <= '0;
            s2_eq_q    <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_data_q <= s1_data_q;
                s2_seg_q  <= seg_d;
                s2_eq_q   <= s2_eq_d;
            end
        end
    end

    // A clear coincident with a delivery seeds the statistics with that
    // sample rather than returning to the empty state.
    always_comb begin
        stat_valid_d = stat_valid_q;
        stat_min_d   = stat_min_q;
        stat_max_d   = stat_max_q;
        if (stat_clr && out_hs) begin
            stat_valid_d = 1'b1;
            stat_min_d   = s2_data_q;
            stat_max_d   = s2_data_q;
        end else if (stat_clr) begin
            stat_valid_d = 1'b0;
            stat_min_d   = C_MOST_POS;
            stat_max_d   = C_MOST_NEG;
        end else if (out_hs) begin
            stat_valid_d = 1'b1;
            if ($signed(s2_data_q) < $signed(stat_min_q)) begin
                stat_min_d = s2_data_q;
            end
            if ($signed(s2_data_q) > $signed(stat_max_q)) begin
                stat_max_d = s2_data_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_valid_q <= 1'b0;
            stat_min_q   <= C_MOST_POS;
            stat_max_q   <= C_MOST_NEG;
        end else begin
            stat_valid_q <= stat_valid_d;
            stat_min_q   <= stat_min_d;
            stat_max_q   <= stat_max_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_data   = s2_data_q;
    assign out_seg    = s2_seg_q;
    assign out_eq     = s2_eq_q;
    assign stat_valid = stat_valid_q;
    assign stat_min   = stat_min_q;
    assign stat_max   = stat_max_q;

endmodule
`default_nettype wire

// File: tb/tb_fixed_point_segment_classifier.sv
`default_nettype none
// ============================================================================
// Module   : tb_fixed_point_segment_classifier
// Purpose  : Scoreboard bench for fixed_point_segment_classifier. The driver
//            pushes hand-computed expectations as samples are accepted. A
//            monitor pops and compares them on every output handshake, and
//            also checks that outputs hold steady while stalled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fixed_point_segment_classifier;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [11:0] cfg_data;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_data;
    logic [2:0]  out_seg;
    logic        out_eq;
    logic        stat_clr;
    logic        stat_valid;
    logic [11:0] stat_min;
    logic [11:0] stat_max;

    fixed_point_segment_classifier dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_seg    (out_seg),
        .out_eq     (out_eq),
        .stat_clr   (stat_clr),
        .stat_valid (stat_valid),
        .stat_min   (stat_min),
        .stat_max   (stat_max)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] data;
        logic [2:0]  seg;
        logic        eq;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          errors  = 0;
    int          cyc     = 0;
    bit          prev_stall = 0;
    logic [11:0] prev_data;
    logic [2:0]  prev_seg;
    logic        prev_eq;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pop on handshake, verify hold during stalls.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall && out_valid) begin
                check("hold_data", 32'(out_data), 32'(prev_data));
                check("hold_seg",  32'(out_seg),  32'(prev_seg));
                check("hold_eq",   32'(out_eq),   32'(prev_eq));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    check("out_data", 32'(out_data), 32'(x.data));
                    check("out_seg",  32'(out_seg),  32'(x.seg));
                    check("out_eq",   32'(out_eq),   32'(x.eq));
                    if (x.lat) check("latency", 32'(cyc - x.acc), 32'd2);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_seg   = out_seg;
            prev_eq    = out_eq;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [11:0] d, input logic [2:0] s, input logic e, input bit lat);
        exp_t x;
        bit   ok;
        ok = 0;
        in_valid = 1'b1;
        in_data  = d;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        x.data = d; x.seg = s; x.eq = e; x.acc = cyc; x.lat = lat;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (!ok) check("send_timeout", 32'd0, 32'd1);
        else sb.push_back(x);
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [11:0] v);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = v;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("drain_timeout", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1; stat_clr = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid",  32'(out_valid),  32'd0);
        check("rst_in_ready",   32'(in_ready),   32'd1);
        check("rst_out_data",   32'(out_data),   32'h000);
        check("rst_out_seg",    32'(out_seg),    32'd0);
        check("rst_out_eq",     32'(out_eq),     32'd0);
        check("rst_stat_valid", 32'(stat_valid), 32'd0);
        check("rst_stat_min",   32'(stat_min),   32'h7FF);
        check("rst_stat_max",   32'(stat_max),   32'h800);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Main stream: T = {-2.0, -0.5, 0.5, 2.0}
        cfg_write(2'd0, 12'hF80);
        cfg_write(2'd1, 12'hFE0);
        cfg_write(2'd2, 12'h020);
        cfg_write(2'd3, 12'h080);
        send(12'h000, 3'd2, 1'b0, 1);
        send(12'h080, 3'd4, 1'b1, 1);
        send(12'h800, 3'd0, 1'b0, 1);
        send(12'h7FF, 3'd4, 1'b0, 1);
        send(12'hFE0, 3'd2, 1'b1, 1);
        drain();

        // Signed corner: T = {0, -0.5, 0.5, 2.0}
        cfg_write(2'd0, 12'h000);
        send(12'hFFF, 3'd1, 1'b0, 1);
        send(12'h001, 3'd2, 1'b0, 1);
        drain();

        // Backpressure: only two samples fit, third waits
        out_ready = 1'b0;
        send(12'h010, 3'd2, 1'b0, 0);
        send(12'h020, 3'd3, 1'b1, 0);
        fork
            send(12'h030, 3'd3, 1'b0, 0);
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("bp_in_ready", 32'(in_ready), 32'd0);
                    check("bp_out_valid", 32'(out_valid), 32'd1);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Config race: old T[2]=0x020 applies to the coincident sample
        cfg_we = 1'b1; cfg_addr = 2'd2; cfg_data = 12'h010;
        send(12'h010, 3'd2, 1'b0, 1);
        cfg_we = 1'b0;
        send(12'h010, 3'd3, 1'b1, 1);
        drain();

        // Statistics: T = {0, -0.5, 0x010, 2.0}
        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
        check("clr_stat_valid", 32'(stat_valid), 32'd0);
        check("clr_stat_min",   32'(stat_min),   32'h7FF);
        check("clr_stat_max",   32'(stat_max),   32'h800);
        send(12'h040, 3'd3, 1'b0, 1);
        send(12'hFC0, 3'd0, 1'b0, 1);
        send(12'h010, 3'd3, 1'b1, 1);
        drain();
        check("stat_valid", 32'(stat_valid), 32'd1);
        check("stat_min",   32'(stat_min),   32'hFC0);
        check("stat_max",   32'(stat_max),   32'h040);
        send(12'h005, 3'd2, 1'b0, 1);
        @(posedge clk); #1;
        stat_clr = 1'b1;
        @(negedge clk);
        check("seed_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        stat_clr = 1'b0;
        check("seed_stat_valid", 32'(stat_valid), 32'd1);
        check("seed_stat_min",   32'(stat_min),   32'h005);
        check("seed_stat_max",   32'(stat_max),   32'h005);
        drain();

        // Mid-stream asynchronous reset with two samples in flight
        out_ready = 1'b0;
        send(12'h011, 3'd0, 1'b0, 0);
        send(12'h022, 3'd0, 1'b0, 0);
        check("inflight_out_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready",  32'(in_ready),   32'd1);
        check("post_rst_out_valid", 32'(out_valid),  32'd0);
        check("post_rst_stat_min",  32'(stat_min),   32'h7FF);
        @(posedge clk); #1;
        send(12'h000, 3'd4, 1'b1, 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
